ahb_spi_master_param: RTL and testbench
=======================================

AHB_SPI_MASTER_PARAM -- requirements
Module: ahb_spi_master_param

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the SPI frame width in bits (legal 4..16).
REQ-002 Parameter NUM_CS, default 2, SHALL set the number of active-low chip selects (legal 1..8).
REQ-003 Parameter DIV_W, default 8, SHALL set the clock-divider register width.
REQ-004 Parameter FIFO_DEPTH, default 4, SHALL set the RX FIFO depth (power of 2, ≥2).
REQ-005 Ports SHALL be: HCLK in 1 bus clock; HRESET in 1 reset; HSEL in 1; HREADY in 1; HADDR in 32; HTRANS in 2; HWRITE in 1; HWDATA in 32; MISO in 1; HRDATA out 32; HREADYOUT out 1; SCLK out 1; MOSI out 1; CS_N out NUM_CS; IRQ out 1.
REQ-006 The block SHALL use one clock, HCLK; HRESET SHALL be asynchronous and active-high.

Function
REQ-007 Address phase (HSEL & HTRANS[1] & HREADY) SHALL register HADDR[3:2] and HWRITE; register access occurs in the data phase; HREADYOUT SHALL be constant 1.
REQ-008 Map by HADDR[3:2]: 0 CTRL, 1 DIV, 2 TXDATA, 3 RXDATA; HRDATA zero-pads unused bits.
REQ-009 CTRL RW: [NUM_CS-1:0] CS_EN, [8] CPOL, [9] CPHA, [10] IRQ_EN; RO: [16] BUSY, [17] RX_NE, [18] RX_OVR, [19] WCOL, [20] DONE.
REQ-010 Writing 1 to CTRL[18], [19] or [20] SHALL clear that sticky bit; writing 0 SHALL leave it.
REQ-011 CS_N[i] SHALL equal ~CS_EN[i], registered, independent of BUSY.
REQ-012 FSM states IDLE and XFER; TXDATA write in IDLE SHALL load HWDATA[DATA_W-1:0] and enter XFER the next cycle with BUSY=1.
REQ-013 TXDATA write in XFER SHALL be ignored and set WCOL; writes to DIV, CPOL or CPHA in XFER SHALL be ignored and set WCOL; CS_EN writes always take effect.
REQ-014 Half-period of SCLK SHALL be (DIV+1) HCLK cycles; a frame SHALL last exactly 2*DATA_W*(DIV+1) cycles; DIV=0 gives HCLK/2.
REQ-015 SCLK SHALL rest at CPOL in IDLE and toggle 2*DATA_W times per frame, ending at CPOL.
REQ-016 Data SHALL be MSB first; CPHA=0: MOSI valid on entry to XFER, MISO sampled on leading edges, MOSI shifts on trailing edges; CPHA=1: MOSI shifts on leading, MISO sampled on trailing.
REQ-017 MOSI SHALL be 0 in IDLE.
REQ-018 On the final edge FSM SHALL return to IDLE, BUSY=0, DONE=1, and push the received frame to RX storage in the same cycle.
REQ-019 Push to full RX storage SHALL drop the frame and set RX_OVR; simultaneous pop and push when full SHALL succeed without overrun.
REQ-020 RXDATA read SHALL return the oldest entry and pop it; read when empty SHALL return 0 with no state change.
REQ-021 IRQ SHALL be registered IRQ_EN & (DONE | RX_OVR).
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; RX_NE SHALL be count≠0.

Reset
REQ-023 HRESET SHALL immediately force: IDLE, BUSY=0, SCLK=0, MOSI=0, CS_N all 1, IRQ=0, CTRL=0, DIV=0, RX storage empty, sticky bits 0.
REQ-024 HRESET during XFER SHALL abort the frame without pushing RX data.

Configuration
REQ-025 Macro SPI_RX_FIFO_EN defined: RX storage SHALL be a FIFO of FIFO_DEPTH entries.
REQ-026 SPI_RX_FIFO_EN undefined: RX storage SHALL be a single holding register (depth 1), FIFO_DEPTH ignored, all other behaviour identical.

Structure
REQ-027 Shared package SHALL hold register-offset constants, CTRL bit-index constants and the FSM state typedef.
REQ-028 RX storage SHALL be sub-module spi_rx_fifo (push, pop, data, empty, full), instantiated with depth 1 when macro is absent.

Verification
REQ-029 DIV=0, CPOL=0, CPHA=0, loopback MOSI->MISO, TXDATA=0xA5 -> BUSY 16 cycles, SCLK 8 rising edges, RXDATA reads 0xA5, DONE=1.
REQ-030 DIV=3, CPOL=1, CPHA=1, DATA_W=16, TXDATA=0x1234 -> frame 128 cycles, SCLK idles high, loopback read 0x1234.
REQ-031 TXDATA write while BUSY -> frame unaltered, WCOL=1; write CTRL[19]=1 -> WCOL=0.
REQ-032 FIFO_DEPTH=4, five frames without reads -> RX_OVR=1, reads return first four frames in order, fifth read returns 0; macro off -> overrun on second frame.
REQ-033 HRESET asserted mid-frame -> SCLK=CPOL reset value 0, CS_N all 1, RX_NE=0 asynchronously.
REQ-034 IRQ_EN=1, frame completes -> IRQ=1 next cycle; clear DONE -> IRQ=0.

Source files
------------

// File: rtl/ahb_spi_master_param_pkg.sv
// Shared register map, CTRL bit positions and FSM state type for the AHB SPI master.
package ahb_spi_master_param_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DIV    = 2'd1;
  localparam logic [1:0] ADDR_TXDATA = 2'd2;
  localparam logic [1:0] ADDR_RXDATA = 2'd3;

  localparam int unsigned CTRL_CPOL   = 8;
  localparam int unsigned CTRL_CPHA   = 9;
  localparam int unsigned CTRL_IRQ_EN = 10;
  localparam int unsigned CTRL_BUSY   = 16;
  localparam int unsigned CTRL_RX_NE  = 17;
  localparam int unsigned CTRL_RX_OVR = 18;
  localparam int unsigned CTRL_WCOL   = 19;
  localparam int unsigned CTRL_DONE   = 20;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_rx_fifo.sv
// RX frame storage: circular FIFO of DEPTH entries; a push while full succeeds
// only when a pop happens in the same cycle.
module spi_rx_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] data,
  output logic              empty,
  output logic              full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [2**AW];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign data    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ahb_spi_master_param.sv
// AHB-Lite slave SPI master with CTRL/DIV/TXDATA/RXDATA registers.
// Define SPI_RX_FIFO_EN for a FIFO_DEPTH-entry RX FIFO; otherwise RX storage is one register.
module ahb_spi_master_param
  import ahb_spi_master_param_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned NUM_CS     = 2,
  parameter int unsigned DIV_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic              HREADY,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [31:0]       HWDATA,
  input  logic              MISO,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              SCLK,
  output logic              MOSI,
  output logic [NUM_CS-1:0] CS_N,
  output logic              IRQ
);

`ifdef SPI_RX_FIFO_EN
  localparam int unsigned RX_DEPTH = FIFO_DEPTH;
`else
  localparam int unsigned RX_DEPTH = 1;
`endif
  localparam int unsigned EDGE_W = $clog2(2 * DATA_W);

  spi_state_e        state;
  logic              dp_valid, dp_write;
  logic [1:0]        dp_addr;
  logic [NUM_CS-1:0] cs_en;
  logic              cpol, cpha, irq_en;
  logic              rx_ovr, wcol, done;
  logic [DIV_W-1:0]  div, div_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic [DATA_W-1:0] tx_sr, rx_sr, rx_next, push_data, rx_data;
  logic              busy, wr_en, rd_en, wr_ctrl, wr_div, wr_tx;
  logic              edge_tick, lead_edge, trail_edge, last_edge;
  logic              sample_edge, shift_edge, mode_chg, wcol_set;
  logic              rx_push, rx_pop, rx_empty, rx_full, rx_ovr_set;
  logic              unused_bits;

  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA};
  assign HREADYOUT   = 1'b1;

  assign busy    = (state == ST_XFER);
  assign wr_en   = dp_valid & dp_write;
  assign rd_en   = dp_valid & ~dp_write;
  assign wr_ctrl = wr_en & (dp_addr == ADDR_CTRL);
  assign wr_div  = wr_en & (dp_addr == ADDR_DIV);
  assign wr_tx   = wr_en & (dp_addr == ADDR_TXDATA);
  assign rx_pop  = rd_en & (dp_addr == ADDR_RXDATA) & ~rx_empty;

  // Edge k of the frame: even k is the leading edge, odd k the trailing edge.
  assign edge_tick   = busy & (div_cnt == div);
  assign lead_edge   = edge_tick & ~edge_cnt[0];
  assign trail_edge  = edge_tick & edge_cnt[0];
  assign last_edge   = edge_tick & (edge_cnt == EDGE_W'(2 * DATA_W - 1));
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;

  assign rx_next    = {rx_sr[DATA_W-2:0], MISO};
  assign push_data  = cpha ? rx_next : rx_sr;
  assign rx_push    = last_edge;
  assign rx_ovr_set = rx_push & rx_full & ~rx_pop;

  // Mode bits are frozen during a frame; only an attempted change counts as a collision.
  assign mode_chg = wr_ctrl & ((HWDATA[CTRL_CPOL] != cpol) | (HWDATA[CTRL_CPHA] != cpha));
  assign wcol_set = busy & (wr_tx | wr_div | mode_chg);

  spi_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (HCLK),
    .rst   (HRESET),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (push_data),
    .data  (rx_data),
    .empty (rx_empty),
    .full  (rx_full)
  );

  always_comb begin
    HRDATA = '0;
    case (dp_addr)
      ADDR_CTRL: begin
        HRDATA[NUM_CS-1:0]  = cs_en;
        HRDATA[CTRL_CPOL]   = cpol;
        HRDATA[CTRL_CPHA]   = cpha;
        HRDATA[CTRL_IRQ_EN] = irq_en;
        HRDATA[CTRL_BUSY]   = busy;
        HRDATA[CTRL_RX_NE]  = ~rx_empty;
        HRDATA[CTRL_RX_OVR] = rx_ovr;
        HRDATA[CTRL_WCOL]   = wcol;
        HRDATA[CTRL_DONE]   = done;
      end
      ADDR_DIV:    HRDATA[DIV_W-1:0] = div;
      ADDR_RXDATA: if (!rx_empty) HRDATA[DATA_W-1:0] = rx_data;
      default:     HRDATA = '0;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= ST_IDLE;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
      cs_en    <= '0;
      cpol     <= 1'b0;
      cpha     <= 1'b0;
      irq_en   <= 1'b0;
      rx_ovr   <= 1'b0;
      wcol     <= 1'b0;
      done     <= 1'b0;
      div      <= '0;
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      SCLK     <= 1'b0;
      MOSI     <= 1'b0;
      CS_N     <= '1;
      IRQ      <= 1'b0;
    end else begin
      dp_valid <= HSEL & HTRANS[1] & HREADY;
      if (HSEL & HTRANS[1] & HREADY) begin
        dp_addr  <= HADDR[3:2];
        dp_write <= HWRITE;
      end
      CS_N <= ~cs_en;
      IRQ  <= irq_en & (done | rx_ovr);

      if (wr_ctrl) begin
        cs_en  <= HWDATA[NUM_CS-1:0];
        irq_en <= HWDATA[CTRL_IRQ_EN];
        if (!busy) begin
          cpol <= HWDATA[CTRL_CPOL];
          cpha <= HWDATA[CTRL_CPHA];
        end
      end
      if (wr_div && !busy) div <= HWDATA[DIV_W-1:0];

      rx_ovr <= (rx_ovr & ~(wr_ctrl & HWDATA[CTRL_RX_OVR])) | rx_ovr_set;
      wcol   <= (wcol & ~(wr_ctrl & HWDATA[CTRL_WCOL])) | wcol_set;
      done   <= (done & ~(wr_ctrl & HWDATA[CTRL_DONE])) | last_edge;

      case (state)
        ST_IDLE: begin
          SCLK     <= cpol;
          MOSI     <= 1'b0;
          div_cnt  <= '0;
          edge_cnt <= '0;
          if (wr_tx) begin
            state <= ST_XFER;
            if (cpha) begin
              tx_sr <= HWDATA[DATA_W-1:0];
            end else begin
              MOSI  <= HWDATA[DATA_W-1];
              tx_sr <= {HWDATA[DATA_W-2:0], 1'b0};
            end
          end
        end
        ST_XFER: begin
          if (edge_tick) begin
            div_cnt  <= '0;
            SCLK     <= ~SCLK;
            edge_cnt <= edge_cnt + EDGE_W'(1);
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
          if (sample_edge) rx_sr <= rx_next;
          if (shift_edge) begin
            if (last_edge) begin
              MOSI <= 1'b0;
            end else begin
              MOSI  <= tx_sr[DATA_W-1];
              tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end
          end
          if (last_edge) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_spi_master_param.sv
// Self-checking bench: an 8-bit and a 16-bit instance in MOSI->MISO loopback,
// RX frames tracked by a scoreboard queue that models the RX storage depth.
module tb_ahb_spi_master_param;

`ifdef SPI_RX_FIFO_EN
  localparam int unsigned EXP_DEPTH = 4;
`else
  localparam int unsigned EXP_DEPTH = 1;
`endif
  localparam logic [31:0] A_CTRL = 32'h0;
  localparam logic [31:0] A_DIV  = 32'h4;
  localparam logic [31:0] A_TX   = 32'h8;
  localparam logic [31:0] A_RX   = 32'hC;
  localparam logic [31:0] B_CPOL = 32'h1 << 8;
  localparam logic [31:0] B_CPHA = 32'h1 << 9;
  localparam logic [31:0] B_IRQE = 32'h1 << 10;
  localparam logic [31:0] B_BUSY = 32'h1 << 16;
  localparam logic [31:0] B_RXNE = 32'h1 << 17;
  localparam logic [31:0] B_OVR  = 32'h1 << 18;
  localparam logic [31:0] B_WCOL = 32'h1 << 19;
  localparam logic [31:0] B_DONE = 32'h1 << 20;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        hsel, sel16;

  logic [31:0] hrdata_a, hrdata_b, hrdata;
  logic        hready_a, hready_b;
  logic        sclk_a, sclk_b, sclk, mosi_a, mosi_b, mosi, irq_a, irq_b, irq;
  logic [1:0]  cs_n_a, cs_n_b, cs_n;

  int          checks = 0;
  int          passed = 0;
  logic [15:0] sb [$];
  logic        exp_ovr;

  always #5 HCLK = ~HCLK;

  ahb_spi_master_param #(.DATA_W(8), .NUM_CS(2), .DIV_W(8), .FIFO_DEPTH(4)) dut_a (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel & ~sel16), .HREADY(HREADY), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .MISO(mosi_a), .HRDATA(hrdata_a),
    .HREADYOUT(hready_a), .SCLK(sclk_a), .MOSI(mosi_a), .CS_N(cs_n_a), .IRQ(irq_a)
  );

  ahb_spi_master_param #(.DATA_W(16), .NUM_CS(2), .DIV_W(8), .FIFO_DEPTH(4)) dut_b (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel & sel16), .HREADY(HREADY), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .MISO(mosi_b), .HRDATA(hrdata_b),
    .HREADYOUT(hready_b), .SCLK(sclk_b), .MOSI(mosi_b), .CS_N(cs_n_b), .IRQ(irq_b)
  );

  assign hrdata = sel16 ? hrdata_b : hrdata_a;
  assign sclk   = sel16 ? sclk_b : sclk_a;
  assign mosi   = sel16 ? mosi_b : mosi_a;
  assign cs_n   = sel16 ? cs_n_b : cs_n_a;
  assign irq    = sel16 ? irq_b : irq_a;

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    hsel = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(posedge HCLK); #1;
    hsel = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    hsel = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    @(posedge HCLK); #1;
    hsel = 1'b0; HTRANS = 2'b00;
    @(negedge HCLK);
    d = hrdata;
    @(posedge HCLK); #1;
  endtask

  task automatic model_push(input logic [15:0] d);
    if (sb.size() < EXP_DEPTH) sb.push_back(d);
    else exp_ovr = 1'b1;
  endtask

  // Starts a frame and watches SCLK edge by edge for a bounded number of cycles.
  task automatic run_frame(input int w, input int div, input logic [15:0] d,
                           output int rises, output int last, output logic first_bit);
    logic prev;
    int   bound;
    bus_write(A_TX, 32'(d));
    prev = sclk; rises = 0; last = 0; first_bit = 1'b0;
    bound = 2 * w * (div + 1) + 8;
    for (int c = 1; c <= bound; c++) begin
      @(posedge HCLK); #1;
      if (sclk !== prev) begin
        if (sclk === 1'b1) rises++;
        last = c;
        prev = sclk;
      end
      if (c == div + 1) first_bit = mosi;
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    checks++; if (sclk_a !== 1'b0) $display("FAIL reset_sclk got %b want 0", sclk_a); else passed++;
    checks++; if (mosi_a !== 1'b0) $display("FAIL reset_mosi got %b want 0", mosi_a); else passed++;
    checks++; if (cs_n_a !== 2'b11) $display("FAIL reset_cs_n got %b want 11", cs_n_a); else passed++;
    checks++; if (irq_a !== 1'b0) $display("FAIL reset_irq got %b want 0", irq_a); else passed++;
    checks++; if (hready_a !== 1'b1 || hready_b !== 1'b1)
      $display("FAIL reset_hreadyout got %b%b want 11", hready_a, hready_b); else passed++;
    HRESET = 1'b0;
    @(posedge HCLK); #1;
    bus_read(A_CTRL, rd);
    checks++; if (rd !== 32'h0) $display("FAIL reset_ctrl got %h want 00000000", rd); else passed++;
    bus_read(A_DIV, rd);
    checks++; if (rd !== 32'h0) $display("FAIL reset_div got %h want 00000000", rd); else passed++;
    bus_read(A_RX, rd);
    checks++; if (rd !== 32'h0) $display("FAIL reset_rx_empty got %h want 00000000", rd); else passed++;
  endtask

  task automatic test_basic_mode0();
    logic [31:0] rd, exp;
    int rises, last;
    logic fb;
    bus_write(A_DIV, 32'h0);
    bus_write(A_CTRL, 32'h1);
    @(posedge HCLK); #1;
    checks++; if (cs_n !== 2'b10) $display("FAIL cs_n_follow got %b want 10", cs_n); else passed++;
    model_push(16'h00A5);
    run_frame(8, 0, 16'h00A5, rises, last, fb);
    checks++; if (rises !== 8) $display("FAIL mode0_rises got %0d want 8", rises); else passed++;
    checks++; if (last !== 16) $display("FAIL mode0_frame_len got %0d want 16", last); else passed++;
    checks++; if (fb !== 1'b1) $display("FAIL mode0_msb_first got %b want 1", fb); else passed++;
    checks++; if (sclk !== 1'b0 || mosi !== 1'b0)
      $display("FAIL mode0_idle got sclk=%b mosi=%b want 0 0", sclk, mosi); else passed++;
    bus_read(A_CTRL, rd);
    exp = 32'h1 | B_RXNE | B_DONE;
    checks++; if (rd !== exp) $display("FAIL mode0_ctrl got %h want %h", rd, exp); else passed++;
    for (int i = 0; i < 2; i++) begin
      bus_read(A_RX, rd);
      exp = (sb.size() != 0) ? 32'(sb.pop_front()) : 32'h0;
      checks++; if (rd !== exp) $display("FAIL mode0_rx%0d got %h want %h", i, rd, exp); else passed++;
    end
    bus_write(A_CTRL, 32'h1 | B_DONE);
    bus_read(A_CTRL, rd);
    checks++; if (rd !== 32'h1) $display("FAIL done_clear got %h want 00000001", rd); else passed++;
  endtask

  task automatic test_wcol();
    logic [31:0] rd, exp;
    bus_write(A_DIV, 32'h3);
    model_push(16'h003C);
    bus_write(A_TX, 32'h3C);
    bus_read(A_CTRL, rd);
    exp = 32'h1 | B_BUSY;
    checks++; if (rd !== exp) $display("FAIL wcol_busy got %h want %h", rd, exp); else passed++;
    bus_write(A_TX, 32'hFF);
    bus_write(A_DIV, 32'h0);
    repeat (80) @(posedge HCLK);
    #1;
    bus_read(A_CTRL, rd);
    exp = 32'h1 | B_RXNE | B_WCOL | B_DONE;
    checks++; if (rd !== exp) $display("FAIL wcol_ctrl got %h want %h", rd, exp); else passed++;
    bus_read(A_DIV, rd);
    checks++; if (rd !== 32'h3) $display("FAIL wcol_div_kept got %h want 00000003", rd); else passed++;
    bus_read(A_RX, rd);
    exp = (sb.size() != 0) ? 32'(sb.pop_front()) : 32'h0;
    checks++; if (rd !== exp) $display("FAIL wcol_frame got %h want %h", rd, exp); else passed++;
    bus_write(A_CTRL, 32'h1 | B_WCOL | B_DONE);
    bus_read(A_CTRL, rd);
    checks++; if (rd !== 32'h1) $display("FAIL wcol_clear got %h want 00000001", rd); else passed++;
    bus_write(A_DIV, 32'h0);
  endtask

  task automatic test_overrun();
    logic [31:0] rd, exp;
    exp_ovr = 1'b0;
    for (int f = 1; f <= 5; f++) begin
      model_push(16'(f * 16'h11));
      bus_write(A_TX, 32'(f * 16'h11));
      repeat (24) @(posedge HCLK);
      #1;
    end
    bus_read(A_CTRL, rd);
    exp = 32'h1 | B_RXNE | B_DONE | (exp_ovr ? B_OVR : 32'h0);
    checks++; if (rd !== exp) $display("FAIL ovr_ctrl got %h want %h", rd, exp); else passed++;
    for (int i = 0; i < 5; i++) begin
      bus_read(A_RX, rd);
      exp = (sb.size() != 0) ? 32'(sb.pop_front()) : 32'h0;
      checks++; if (rd !== exp) $display("FAIL ovr_rx%0d got %h want %h", i, rd, exp); else passed++;
    end
    bus_write(A_CTRL, 32'h1 | B_OVR | B_DONE);
    bus_read(A_CTRL, rd);
    checks++; if (rd !== 32'h1) $display("FAIL ovr_clear got %h want 00000001", rd); else passed++;
  endtask

  task automatic test_irq();
    logic [31:0] rd, exp;
    int rise_c;
    bus_write(A_CTRL, 32'h1 | B_IRQE);
    @(posedge HCLK); #1;
    checks++; if (irq !== 1'b0) $display("FAIL irq_idle got %b want 0", irq); else passed++;
    model_push(16'h005A);
    bus_write(A_TX, 32'h5A);
    rise_c = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge HCLK); #1;
      if (irq === 1'b1 && rise_c < 0) rise_c = c;
    end
    checks++; if (rise_c !== 17) $display("FAIL irq_latency got %0d want 17", rise_c); else passed++;
    bus_read(A_RX, rd);
    exp = (sb.size() != 0) ? 32'(sb.pop_front()) : 32'h0;
    checks++; if (rd !== exp) $display("FAIL irq_rx got %h want %h", rd, exp); else passed++;
    bus_write(A_CTRL, 32'h1 | B_IRQE | B_DONE);
    @(posedge HCLK); #1;
    checks++; if (irq !== 1'b0) $display("FAIL irq_clear got %b want 0", irq); else passed++;
    bus_write(A_CTRL, 32'h1);
  endtask

  task automatic test_mode3_wide();
    logic [31:0] rd, exp;
    int rises, last;
    logic fb;
    sel16 = 1'b1;
    bus_write(A_DIV, 32'h3);
    bus_write(A_CTRL, 32'h1 | B_CPOL | B_CPHA);
    @(posedge HCLK); #1;
    checks++; if (sclk !== 1'b1) $display("FAIL mode3_idle_high got %b want 1", sclk); else passed++;
    model_push(16'h1234);
    run_frame(16, 3, 16'h1234, rises, last, fb);
    checks++; if (last !== 128) $display("FAIL mode3_frame_len got %0d want 128", last); else passed++;
    checks++; if (rises !== 16) $display("FAIL mode3_rises got %0d want 16", rises); else passed++;
    checks++; if (fb !== 1'b0) $display("FAIL mode3_msb_first got %b want 0", fb); else passed++;
    checks++; if (sclk !== 1'b1) $display("FAIL mode3_end_high got %b want 1", sclk); else passed++;
    bus_read(A_RX, rd);
    exp = (sb.size() != 0) ? 32'(sb.pop_front()) : 32'h0;
    checks++; if (rd !== exp) $display("FAIL mode3_rx got %h want %h", rd, exp); else passed++;
    bus_write(A_CTRL, 32'h1 | B_CPOL | B_CPHA | B_DONE);
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rd;
    bus_write(A_TX, 32'hBEEF);
    repeat (20) @(posedge HCLK);
    #3;
    HRESET = 1'b1;
    #1;
    checks++; if (sclk !== 1'b0) $display("FAIL abort_sclk got %b want 0", sclk); else passed++;
    checks++; if (cs_n !== 2'b11) $display("FAIL abort_cs_n got %b want 11", cs_n); else passed++;
    checks++; if (mosi !== 1'b0) $display("FAIL abort_mosi got %b want 0", mosi); else passed++;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    sb.delete();
    repeat (40) @(posedge HCLK);
    #1;
    bus_read(A_CTRL, rd);
    checks++; if (rd !== 32'h0) $display("FAIL abort_ctrl got %h want 00000000", rd); else passed++;
    bus_read(A_RX, rd);
    checks++; if (rd !== 32'h0) $display("FAIL abort_rx got %h want 00000000", rd); else passed++;
  endtask

  initial begin
    hsel = 1'b0; sel16 = 1'b0; HREADY = 1'b1; HADDR = '0; HTRANS = 2'b00;
    HWRITE = 1'b0; HWDATA = '0; exp_ovr = 1'b0;
    test_reset();
    test_basic_mode0();
    test_wcol();
    test_overrun();
    test_irq();
    test_mode3_wide();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
